mips_multicycle_control: RTL and testbench

Multicycle control FSM for the MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and writeback. Drives the 4-bit ALU operation code, operand selects and the Zero-qualified PC write to the shared ALU. Holds in memory-access states until the memory handshake completes.

---
 rtl/mips_ctrl_pkg.sv | 55 +++++
 rtl/mips_multicycle_control_alu_op_decode.sv | 54 +++++
 rtl/mips_multicycle_control.sv | 154 +++++++++++++++
 tb/tb_mips_multicycle_control.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcode/funct constants, ALU op codes and control FSM types
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLT   = 6'h06;
    localparam logic [5:0] OP_BGT   = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_MULT = 6'h18;
    localparam logic [5:0] FN_DIV  = 6'h1A;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOT  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SGT  = 6'h2B;
    localparam logic [5:0] FN_SLET = 6'h2C;
    localparam logic [5:0] FN_SGET = 6'h2D;
    localparam logic [5:0] FN_SET  = 6'h2E;
    localparam logic [5:0] FN_SDT  = 6'h2F;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd3;
    localparam logic [3:0] ALU_LT  = 4'd4;
    localparam logic [3:0] ALU_GT  = 4'd5;
    localparam logic [3:0] ALU_NOT = 4'd6;
    localparam logic [3:0] ALU_MUL = 4'd7;
    localparam logic [3:0] ALU_DIV = 4'd8;
    localparam logic [3:0] ALU_SLL = 4'd9;
    localparam logic [3:0] ALU_SRL = 4'd10;
    localparam logic [3:0] ALU_LE  = 4'd11;
    localparam logic [3:0] ALU_GE  = 4'd12;
    localparam logic [3:0] ALU_EQ  = 4'd13;
    localparam logic [3:0] ALU_NE  = 4'd14;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_RTEX, S_RTWB, S_ITEX, S_ITWB, S_BRANCH, S_JUMP
    } state_e;

    typedef enum logic [2:0] {C_LW, C_SW, C_RT, C_IT, C_BR, C_J} cls_e;

endpackage

// File: rtl/mips_multicycle_control_alu_op_decode.sv
// alu_op_decode: opcode/funct to ALU op, branch sense, instruction class and legality
module alu_op_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic [3:0] ex_op_o,
    output logic       brz_o,
    output cls_e       cls_o,
    output logic       legal_o
);

    // brz_o is the Zero value that makes a branch taken (1 only for beq)
    always_comb begin
        ex_op_o = ALU_ADD;
        brz_o   = 1'b0;
        cls_o   = C_RT;
        legal_o = 1'b1;
        case (opcode_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_AND:  ex_op_o = ALU_AND;
                    FN_OR:   ex_op_o = ALU_OR;
                    FN_ADD:  ex_op_o = ALU_ADD;
                    FN_SUB:  ex_op_o = ALU_SUB;
                    FN_SLT:  ex_op_o = ALU_LT;
                    FN_SGT:  ex_op_o = ALU_GT;
                    FN_NOT:  ex_op_o = ALU_NOT;
                    FN_MULT: ex_op_o = ALU_MUL;
                    FN_DIV:  ex_op_o = ALU_DIV;
                    FN_SLL:  ex_op_o = ALU_SLL;
                    FN_SRL:  ex_op_o = ALU_SRL;
                    FN_SLET: ex_op_o = ALU_LE;
                    FN_SGET: ex_op_o = ALU_GE;
                    FN_SET:  ex_op_o = ALU_EQ;
                    FN_SDT:  ex_op_o = ALU_NE;
                    default: legal_o = 1'b0;
                endcase
            end
            OP_LW:   cls_o = C_LW;
            OP_SW:   cls_o = C_SW;
            OP_BEQ:  begin cls_o = C_BR; ex_op_o = ALU_SUB; brz_o = 1'b1; end
            OP_BNE:  begin cls_o = C_BR; ex_op_o = ALU_SUB; end
            OP_BLT:  begin cls_o = C_BR; ex_op_o = ALU_LT; end
            OP_BGT:  begin cls_o = C_BR; ex_op_o = ALU_GT; end
            OP_ADDI: cls_o = C_IT;
            OP_ANDI: begin cls_o = C_IT; ex_op_o = ALU_AND; end
            OP_ORI:  begin cls_o = C_IT; ex_op_o = ALU_OR; end
            OP_J:    cls_o = C_J;
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: multicycle MIPS control FSM driving the shared ALU and memory strobes
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int CONTROL_WIDTH = 4
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [5:0]               opcode_i,
    input  logic [5:0]               funct_i,
    input  logic                     zero_i,
    input  logic                     mem_ready_i,
    output logic [CONTROL_WIDTH-1:0] alu_ctrl_o,
    output logic                     alu_src_a_o,
    output logic [1:0]               alu_src_b_o,
    output logic                     imm_zext_o,
    output logic                     iord_o,
    output logic                     mem_read_o,
    output logic                     mem_write_o,
    output logic                     ir_write_o,
    output logic                     reg_write_o,
    output logic                     pc_write_o,
    output logic                     reg_dst_o,
    output logic                     mem_to_reg_o,
    output logic [1:0]               pc_src_o,
    output logic                     illegal_o,
    output logic [3:0]               state_dbg_o
);

    state_e     state_q, state_d;
    logic [3:0] ex_op_q, ex_op;
    logic       brz_q, brz, legal;
    cls_e       cls_q, cls;

    alu_op_decode u_dec (
        .opcode_i (opcode_i),
        .funct_i  (funct_i),
        .ex_op_o  (ex_op),
        .brz_o    (brz),
        .cls_o    (cls),
        .legal_o  (legal)
    );

    // State register; decode results are captured only in DECODE so IR may change afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ex_op_q <= ALU_ADD;
            brz_q   <= 1'b0;
            cls_q   <= C_RT;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                ex_op_q <= ex_op;
                brz_q   <= brz;
                cls_q   <= cls;
            end
        end
    end

    // Next-state logic; memory states hold until mem_ready_i
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE: state_d = !legal ? S_FETCH :
                                (cls == C_LW || cls == C_SW) ? S_MEMADR :
                                cls == C_RT ? S_RTEX :
                                cls == C_IT ? S_ITEX :
                                cls == C_BR ? S_BRANCH : S_JUMP;
            S_MEMADR: state_d = cls_q == C_SW ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = mem_ready_i ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = mem_ready_i ? S_FETCH : S_MEMWR;
            S_RTEX:   state_d = S_RTWB;
            S_ITEX:   state_d = S_ITWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Moore output decode; FETCH ir/pc writes and BRANCH pc write are gated combinationally
    always_comb begin
        alu_ctrl_o   = CONTROL_WIDTH'(ALU_ADD);
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'd0;
        imm_zext_o   = 1'b0;
        iord_o       = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        ir_write_o   = 1'b0;
        reg_write_o  = 1'b0;
        pc_write_o   = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        pc_src_o     = 2'd0;
        illegal_o    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'd1;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
            end
            S_DECODE: begin
                alu_src_b_o = 2'd3;
                illegal_o   = !legal;
            end
            S_MEMADR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'd2;
            end
            S_MEMRD: begin
                iord_o     = 1'b1;
                mem_read_o = 1'b1;
            end
            S_MEMWB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
            end
            S_MEMWR: begin
                iord_o      = 1'b1;
                mem_write_o = 1'b1;
            end
            S_RTEX: begin
                alu_src_a_o = 1'b1;
                alu_ctrl_o  = CONTROL_WIDTH'(ex_op_q);
            end
            S_RTWB: begin
                reg_write_o = 1'b1;
                reg_dst_o   = 1'b1;
            end
            S_ITEX: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'd2;
                imm_zext_o  = ex_op_q != ALU_ADD;
                alu_ctrl_o  = CONTROL_WIDTH'(ex_op_q);
            end
            S_ITWB:   reg_write_o = 1'b1;
            S_BRANCH: begin
                alu_src_a_o = 1'b1;
                alu_ctrl_o  = CONTROL_WIDTH'(ex_op_q);
                pc_src_o    = 2'd1;
                pc_write_o  = zero_i == brz_q;
            end
            S_JUMP: begin
                pc_src_o   = 2'd2;
                pc_write_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: table-driven cycle-by-cycle check of the multicycle control FSM
module tb_mips_multicycle_control;

    localparam logic [3:0] IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEMADR = 4'd3,
                           MEMRD = 4'd4, MEMWB = 4'd5, MEMWR = 4'd6, RTEX = 4'd7,
                           RTWB = 4'd8, ITEX = 4'd9, ITWB = 4'd10, BRANCH = 4'd11, JUMP = 4'd12;

    localparam logic [9:0] F_ZX  = 10'b10_0000_0000, F_IORD = 10'b01_0000_0000,
                           F_MR  = 10'b00_1000_0000, F_MW   = 10'b00_0100_0000,
                           F_IRW = 10'b00_0010_0000, F_RW   = 10'b00_0001_0000,
                           F_PCW = 10'b00_0000_1000, F_RD   = 10'b00_0000_0100,
                           F_M2R = 10'b00_0000_0010, F_ILL  = 10'b00_0000_0001;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       mr;
        logic [3:0] st;
        logic [3:0] alu;
        logic       sa;
        logic [1:0] sb;
        logic [1:0] ps;
        logic [9:0] fl;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'h00, funct = 6'h00;
    logic       zero = 1'b0, mem_ready = 1'b0;
    logic [3:0] alu_ctrl, state_dbg;
    logic       alu_src_a, imm_zext, iord, mem_read, mem_write, ir_write;
    logic       reg_write, pc_write, reg_dst, mem_to_reg, illegal;
    logic [1:0] alu_src_b, pc_src;
    logic [9:0] flags;
    int         n_run = 0, n_fail = 0;
    vec_t       v[$];

    mips_multicycle_control #(.CONTROL_WIDTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode_i     (opcode),
        .funct_i      (funct),
        .zero_i       (zero),
        .mem_ready_i  (mem_ready),
        .alu_ctrl_o   (alu_ctrl),
        .alu_src_a_o  (alu_src_a),
        .alu_src_b_o  (alu_src_b),
        .imm_zext_o   (imm_zext),
        .iord_o       (iord),
        .mem_read_o   (mem_read),
        .mem_write_o  (mem_write),
        .ir_write_o   (ir_write),
        .reg_write_o  (reg_write),
        .pc_write_o   (pc_write),
        .reg_dst_o    (reg_dst),
        .mem_to_reg_o (mem_to_reg),
        .pc_src_o     (pc_src),
        .illegal_o    (illegal),
        .state_dbg_o  (state_dbg)
    );

    always #5 clk = ~clk;

    assign flags = {imm_zext, iord, mem_read, mem_write, ir_write, reg_write,
                    pc_write, reg_dst, mem_to_reg, illegal};

    function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                input logic mr, input logic [3:0] st, input logic [3:0] alu,
                                input logic sa, input logic [1:0] sb, input logic [1:0] ps,
                                input logic [9:0] fl);
        vec_t r;
        r.op = op; r.fn = fn; r.z = z; r.mr = mr; r.st = st;
        r.alu = alu; r.sa = sa; r.sb = sb; r.ps = ps; r.fl = fl;
        return r;
    endfunction

    // zero-wait fetch followed by a legal decode cycle
    task automatic fd(input logic [5:0] op, input logic [5:0] fn);
        v.push_back(mk(op, fn, 0, 1, FETCH, 2, 0, 1, 0, F_MR | F_IRW | F_PCW));
        v.push_back(mk(op, fn, 0, 1, DECODE, 2, 0, 3, 0, 0));
    endtask

    task automatic check(input string name, input logic [24:0] got, input logic [24:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got st/alu/sa/sb/ps/fl=%h want %h", name, got, exp);
        end
    endtask

    function automatic logic [24:0] pack(input logic [3:0] st, input logic [3:0] alu,
                                          input logic sa, input logic [1:0] sb,
                                          input logic [1:0] ps, input logic [9:0] fl);
        return {st, alu, sa, sb, ps, fl};
    endfunction

    initial begin
        // add, zero-wait
        v.push_back(mk(6'h00, 6'h20, 0, 1, IDLE, 2, 0, 0, 0, 0));
        fd(6'h00, 6'h20);
        v.push_back(mk(6'h00, 6'h20, 0, 1, RTEX, 2, 1, 0, 0, 0));
        v.push_back(mk(6'h00, 6'h20, 0, 1, RTWB, 2, 0, 0, 0, F_RW | F_RD));
        // lw: one fetch wait, two MEMRD waits
        v.push_back(mk(6'h23, 6'h00, 0, 0, FETCH, 2, 0, 1, 0, F_MR));
        fd(6'h23, 6'h00);
        v.push_back(mk(6'h23, 6'h00, 0, 1, MEMADR, 2, 1, 2, 0, 0));
        v.push_back(mk(6'h23, 6'h00, 0, 0, MEMRD, 2, 0, 0, 0, F_IORD | F_MR));
        v.push_back(mk(6'h23, 6'h00, 0, 0, MEMRD, 2, 0, 0, 0, F_IORD | F_MR));
        v.push_back(mk(6'h23, 6'h00, 0, 1, MEMRD, 2, 0, 0, 0, F_IORD | F_MR));
        v.push_back(mk(6'h23, 6'h00, 0, 1, MEMWB, 2, 0, 0, 0, F_RW | F_M2R));
        // beq taken on zero=1
        fd(6'h04, 6'h00);
        v.push_back(mk(6'h04, 6'h00, 1, 1, BRANCH, 3, 1, 0, 1, F_PCW));
        // bne not taken on zero=1
        fd(6'h05, 6'h00);
        v.push_back(mk(6'h05, 6'h00, 1, 1, BRANCH, 3, 1, 0, 1, 0));
        // blt taken on zero=0
        fd(6'h06, 6'h00);
        v.push_back(mk(6'h06, 6'h00, 0, 1, BRANCH, 4, 1, 0, 1, F_PCW));
        // bgt not taken on zero=1
        fd(6'h07, 6'h00);
        v.push_back(mk(6'h07, 6'h00, 1, 1, BRANCH, 5, 1, 0, 1, 0));
        // ori: zero-extended immediate, OR
        fd(6'h0D, 6'h00);
        v.push_back(mk(6'h0D, 6'h00, 0, 1, ITEX, 1, 1, 2, 0, F_ZX));
        v.push_back(mk(6'h0D, 6'h00, 0, 1, ITWB, 2, 0, 0, 0, F_RW));
        // addi: sign-extended immediate, ADD
        fd(6'h08, 6'h00);
        v.push_back(mk(6'h08, 6'h00, 0, 1, ITEX, 2, 1, 2, 0, 0));
        v.push_back(mk(6'h08, 6'h00, 0, 1, ITWB, 2, 0, 0, 0, F_RW));
        // R-type with bad funct: illegal in DECODE only, back to FETCH
        v.push_back(mk(6'h00, 6'h3F, 0, 1, FETCH, 2, 0, 1, 0, F_MR | F_IRW | F_PCW));
        v.push_back(mk(6'h00, 6'h3F, 0, 1, DECODE, 2, 0, 3, 0, F_ILL));
        // bad opcode
        v.push_back(mk(6'h3F, 6'h20, 0, 1, FETCH, 2, 0, 1, 0, F_MR | F_IRW | F_PCW));
        v.push_back(mk(6'h3F, 6'h20, 0, 1, DECODE, 2, 0, 3, 0, F_ILL));
        // sub; funct changes after DECODE and must be ignored
        fd(6'h00, 6'h22);
        v.push_back(mk(6'h00, 6'h24, 0, 1, RTEX, 3, 1, 0, 0, 0));
        v.push_back(mk(6'h00, 6'h24, 0, 1, RTWB, 2, 0, 0, 0, F_RW | F_RD));
        // srl
        fd(6'h00, 6'h02);
        v.push_back(mk(6'h00, 6'h02, 0, 1, RTEX, 10, 1, 0, 0, 0));
        v.push_back(mk(6'h00, 6'h02, 0, 1, RTWB, 2, 0, 0, 0, F_RW | F_RD));
        // j
        fd(6'h02, 6'h00);
        v.push_back(mk(6'h02, 6'h00, 0, 1, JUMP, 2, 0, 0, 2, F_PCW));
        // sw, stalled in MEMWR
        fd(6'h2B, 6'h00);
        v.push_back(mk(6'h2B, 6'h00, 0, 1, MEMADR, 2, 1, 2, 0, 0));
        v.push_back(mk(6'h2B, 6'h00, 0, 0, MEMWR, 2, 0, 0, 0, F_IORD | F_MW));

        // reset state
        #2;
        check("reset", pack(state_dbg, alu_ctrl, alu_src_a, alu_src_b, pc_src, flags),
              pack(IDLE, 2, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;

        foreach (v[i]) begin
            opcode = v[i].op; funct = v[i].fn; zero = v[i].z; mem_ready = v[i].mr;
            #1;
            check($sformatf("vec%0d", i),
                  pack(state_dbg, alu_ctrl, alu_src_a, alu_src_b, pc_src, flags),
                  pack(v[i].st, v[i].alu, v[i].sa, v[i].sb, v[i].ps, v[i].fl));
            @(posedge clk);
            #1;
        end

        // still waiting in MEMWR; async reset must drop mem_write in the same cycle
        mem_ready = 1'b0;
        #1;
        check("memwr_wait", pack(state_dbg, alu_ctrl, alu_src_a, alu_src_b, pc_src, flags),
              pack(MEMWR, 2, 0, 0, 0, F_IORD | F_MW));
        rst = 1'b1;
        #1;
        check("rst_mid_memwr", pack(state_dbg, alu_ctrl, alu_src_a, alu_src_b, pc_src, flags),
              pack(IDLE, 2, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("after_rst_idle", pack(state_dbg, alu_ctrl, alu_src_a, alu_src_b, pc_src, flags),
              pack(IDLE, 2, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        check("after_rst_fetch", pack(state_dbg, alu_ctrl, alu_src_a, alu_src_b, pc_src, flags),
              pack(FETCH, 2, 0, 1, 0, F_MR));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
